// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - requester/FIFO-side bundle for fifo_access_arbiter
//
// Purpose : groups the write/read requester handshakes, the drain control and
//           the FIFO-facing strobes/status into one bundle.
// Ports   : req0/wdata0/gnt0, req1/wdata1/gnt1   write requesters
//           rd_req/rd_gnt                         read requester
//           drain/drain_done                      flush command and completion pulse
//           fifo_wdata/fifo_winc/fifo_rinc        registered FIFO strobes and data
//           count/full/empty                      occupancy status
// Modports: master = requester side, slave = arbiter side.

interface fifo_access_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              req0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rd_req;
    logic              rd_gnt;
    logic              drain;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_winc;
    logic              fifo_rinc;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              drain_done;

    modport master (
        output req0, wdata0, req1, wdata1, rd_req, drain,
        input  gnt0, gnt1, rd_gnt, fifo_wdata, fifo_winc, fifo_rinc,
               count, full, empty, drain_done
    );

    modport slave (
        input  req0, wdata0, req1, wdata1, rd_req, drain,
        output gnt0, gnt1, rd_gnt, fifo_wdata, fifo_winc, fifo_rinc,
               count, full, empty, drain_done
    );
endinterface

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin write arbiter, read gate, occupancy tracker and drain sequencer
//
// Purpose : arbitrates two write requesters onto one FIFO write port, gates a
//           read requester, tracks occupancy (the FIFO has no flags) and runs
//           a flush sequence on command.
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous reset, active low (0 = reset)
//           bus  - fifo_access_arbiter_if.slave (requesters, drain, FIFO strobes, status)

module fifo_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_access_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t            state_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_wdata_q;
    logic              fifo_winc_q;
    logic              fifo_rinc_q;
    logic              drain_done_q;
    logic              last_wr_q;     // 1 = requester 1 won last, so requester 0 wins the next tie

    logic full_w, empty_w, run_w, wr_ok_w;
    logic gnt0_w, gnt1_w, rd_gnt_w;
    logic wr_acc_w, rd_acc_w;

    always_comb begin
        full_w  = (count_q == DEPTH_C);
        empty_w = (count_q == '0);
        // Grants are held off while reset is asserted so nothing is accepted
        // into a FIFO that is being cleared.
        run_w   = (state_q == RUN) && rst;
        wr_ok_w = run_w && !full_w;

        gnt0_w   = wr_ok_w && bus.req0 && (!bus.req1 ||  last_wr_q);
        gnt1_w   = wr_ok_w && bus.req1 && (!bus.req0 || !last_wr_q);
        rd_gnt_w = run_w && bus.rd_req && !empty_w;

        wr_acc_w = gnt0_w || gnt1_w;
        // During DRAIN the controller itself reads every cycle until empty.
        rd_acc_w = rd_gnt_w || ((state_q == DRAIN) && !empty_w);

        count_d = count_q;
        if (wr_acc_w && !rd_acc_w) begin
            count_d = count_q + ONE_C;
        end else if (rd_acc_w && !wr_acc_w) begin
            count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            count_q      <= '0;
            fifo_wdata_q <= '0;
            fifo_winc_q  <= 1'b0;
            fifo_rinc_q  <= 1'b0;
            drain_done_q <= 1'b0;
            last_wr_q    <= 1'b1;
        end else begin
            count_q      <= count_d;
            fifo_winc_q  <= wr_acc_w;
            fifo_rinc_q  <= rd_acc_w;
            drain_done_q <= 1'b0;

            if (gnt0_w) begin
                fifo_wdata_q <= bus.wdata0;
                last_wr_q    <= 1'b0;
            end else if (gnt1_w) begin
                fifo_wdata_q <= bus.wdata1;
                last_wr_q    <= 1'b1;
            end

            case (state_q)
                RUN: begin
                    if (bus.drain) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave only once the registered count shows empty, so the
                    // last drain read has already been issued.
                    if (count_q == '0) begin
                        state_q      <= DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign bus.gnt0       = gnt0_w;
    assign bus.gnt1       = gnt1_w;
    assign bus.rd_gnt     = rd_gnt_w;
    assign bus.fifo_wdata = fifo_wdata_q;
    assign bus.fifo_winc  = fifo_winc_q;
    assign bus.fifo_rinc  = fifo_rinc_q;
    assign bus.count      = count_q;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.drain_done = drain_done_q;

endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
Front-end controller for the team's 8-bit FIFO. Arbitrates two write requesters round-robin onto the single FIFO write port and gates a read requester. Tracks occupancy, since the FIFO exports no flags, and derives full/empty from it. Provides a drain sequence that flushes the FIFO on command.

Parameters:
DATA_W, 8, data width of requester and FIFO write data
DEPTH, 8, FIFO capacity in entries; must match the FIFO instance
CNT_W, 4, occupancy counter width; equals log2(DEPTH)+1

Ports:
clk  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
req0  input  1  write request, requester 0
wdata0  input  DATA_W  write data, requester 0
gnt0  output  1  combinational grant; wdata0 accepted at this edge
req1  input  1  write request, requester 1
wdata1  input  DATA_W  write data, requester 1
gnt1  output  1  combinational grant; wdata1 accepted at this edge
rd_req  input  1  read request
rd_gnt  output  1  combinational read grant
drain  input  1  start flush; level, sampled in RUN only
fifo_wdata  output  DATA_W  registered data to FIFO wdata
fifo_winc  output  1  registered FIFO write strobe
fifo_rinc  output  1  registered FIFO read strobe
count  output  CNT_W  registered occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
drain_done  output  1  one-cycle pulse, drain complete

Behaviour:
- Reset (rst=0 at edge): state=RUN, count=0, fifo_winc=0, fifo_rinc=0, fifo_wdata=0, drain_done=0, last_wr=1 (requester 0 wins first tie). The FIFO's rst is driven from the same source, so storage and count clear together. Reset mid-drain aborts the drain with no drain_done.
- States:
  - RUN -> DRAIN when drain=1.
  - DRAIN -> DONE when the registered count==0.
  - DONE -> RUN unconditionally after 1 cycle.
- Write grant, RUN only, full=0:
  - One request active: grant it.
  - Both active: grant the requester != last_wr.
  - last_wr updates on every grant.
  - Grants never overlap.
- Read grant: rd_gnt = rd_req & ~empty, in RUN only.
- Latency: an accept at edge N gives fifo_winc/fifo_rinc=1 and fifo_wdata=granted data in cycle N+1. Strobes are one cycle per accept, so back-to-back accepts give continuous strobes.
- count updates at the accept edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read.
- Simultaneous read and write is allowed when 0 < count < DEPTH.
- When full, no write grant even if rd_gnt is high in the same cycle; full is evaluated on the current count.
- When empty, no read grant even if a write is accepted in the same cycle.
- count never exceeds DEPTH and never underflows below 0.
- DRAIN:
  - gnt0 = gnt1 = rd_gnt = 0.
  - Internal read each cycle while count > 0, giving fifo_rinc each cycle.
- DONE: drain_done=1 for exactly one cycle, no grants. A drain still held high in DONE is ignored until the state is back in RUN.
- Requesters hold req and data stable until gnt is seen. A held req is treated as a new request every cycle.

Test Plan:
- Reset: rst=0 for 2 cycles with req0=1 -> no gnt0, count=0, empty=1, full=0, all strobes 0.
- Round-robin: req0=req1=1 held, wdata0=8'd10, wdata1=8'd20 for 4 cycles -> grants 0,1,0,1; fifo_wdata 10,20,10,20 one cycle later; count=4.
- Full: req0=1 with 9 values 1..9, DEPTH=8 -> 8 grants, full=1 at count=8, 9th value not granted until a read occurs; rd_req=1 with req0=1 at full -> rd_gnt=1, gnt0=0, count=7.
- Simultaneous: count=3, req1=1 and rd_req=1 for 3 cycles -> fifo_winc and fifo_rinc both 1 for 3 cycles, count stays 3.
- Empty: count=0, rd_req=1 -> rd_gnt=0, fifo_rinc stays 0; count=0 with rd_req=1 and req0=1 in the same cycle -> only gnt0, count=1.
- Drain: count=5, drain=1 one cycle, req0=1 held -> no grants; fifo_rinc=1 for 5 consecutive cycles; drain_done pulse one cycle after count reaches 0; then gnt0 resumes. Repeat with rst=0 mid-drain -> count=0, no drain_done.
